cache_fill_arbiter: RTL

Parametrised two-channel cache fill controller that serves I-cache and D-cache misses over one shared, pipelined memory port. It latches a block-aligned miss address and issues one read request per word with ready/valid backpressure. It counts in-order responses independently of requests and drives per-channel data-array and tag-array write enables. It sits between the two caches' tag-match logic and the memory interface, and its busy outputs are the pipeline stall signals.

---
 rtl/cache_fill_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cache_fill_arbiter.sv
// Two-channel cache fill controller: arbitrates D/I misses (D first) onto one
// pipelined read port, counts in-order responses and drives array write enables.
module cache_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int WORD_BYTES  = 2,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  output logic                           d_busy,
  output logic                           i_busy,
  output logic                           d_write_data,
  output logic                           i_write_data,
  output logic                           d_write_tag,
  output logic                           i_write_tag,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_offset,
  output logic [ADDR_W-1:0]              fill_addr,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_ready,
  input  logic                           mem_data_valid
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam int WB_SH = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLOCK_WORDS * WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic               owner_i_r;   // 1: the I-cache owns the current fill
  logic [ADDR_W-1:0]  base_r;
  logic [CNT_W-1:0]   req_cnt_r;
  logic [CNT_W-1:0]   resp_cnt_r;
  logic               grant_s;
  logic               grant_i_s;
  logic [ADDR_W-1:0]  miss_addr_s;
  logic               in_idle_s;
  logic               in_fill_s;
  logic               in_done_s;
  logic               req_fire_s;
  logic               resp_fire_s;

  assign in_idle_s   = (state_r == ST_IDLE);
  assign in_fill_s   = (state_r == ST_FILL);
  assign in_done_s   = (state_r == ST_DONE);
  assign req_fire_s  = mem_req & mem_ready;
  // Responses outside FILL are stray and must not touch the arrays or counters.
  assign resp_fire_s = in_fill_s & mem_data_valid;
  assign miss_addr_s = grant_i_s ? i_miss_addr : d_miss_addr;

  // Next-state and grant decode with fixed D-over-I priority.
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 1'b0;
    grant_i_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (d_miss) begin
          grant_s    = 1'b1;
          state_nx_s = ST_FILL;
        end else if (i_miss) begin
          grant_s    = 1'b1;
          grant_i_s  = 1'b1;
          state_nx_s = ST_FILL;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (resp_fire_s && (resp_cnt_r == CNT_LAST)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_FILL;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, owner and block base registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      owner_i_r <= 1'b0;
      base_r    <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (grant_s) begin
        owner_i_r <= grant_i_s;
        base_r    <= miss_addr_s & BASE_MASK;
      end
    end
  end

  // Request and response counters run independently; both clear once the tag is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt_r  <= {CNT_W{1'b0}};
      resp_cnt_r <= {CNT_W{1'b0}};
    end else if (in_done_s) begin
      req_cnt_r  <= {CNT_W{1'b0}};
      resp_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (req_fire_s) begin
        req_cnt_r <= req_cnt_r + CNT_W'(1);
      end
      if (resp_fire_s) begin
        resp_cnt_r <= resp_cnt_r + CNT_W'(1);
      end
    end
  end

  // Request side is derived only from registered state, never from mem_ready.
  assign mem_req  = in_fill_s & (req_cnt_r < CNT_FULL);
  assign mem_addr = mem_req ? (base_r + (ADDR_W'(req_cnt_r) << WB_SH)) : {ADDR_W{1'b0}};

  assign fill_addr    = base_r;
  assign word_offset  = resp_cnt_r[OFF_W-1:0];
  assign d_write_data = resp_fire_s & ~owner_i_r;
  assign i_write_data = resp_fire_s & owner_i_r;
  assign d_write_tag  = in_done_s & ~owner_i_r;
  assign i_write_tag  = in_done_s & owner_i_r;
  assign d_busy       = d_miss | (~owner_i_r & ~in_idle_s);
  assign i_busy       = i_miss | (owner_i_r & ~in_idle_s);

endmodule
